fc_serial_mac: RTL

//  Fully-connected (dense) layer stage directly downstream of the flatten stage.

---
 rtl/fc_serial_mac.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/fc_serial_mac.sv
// ============================================================================
// Module   : fc_serial_mac
// Brief    : Dense layer stage; parallel accumulate of OUT_LEN dot products,
//            serial drain of biased, optionally rectified, saturated results.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fc_serial_mac #(
    parameter int BITWIDTH   = 16,
    parameter int FRAC_BITS  = 8,
    parameter int IN_LEN     = 108,
    parameter int OUT_LEN    = 10,
    parameter int ACC_WIDTH  = 40,
    parameter int RELU       = 0,
    parameter int CNT_WIDTH  = 10,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clken,
    input  logic [BITWIDTH-1:0]   data_in,
    input  logic                  data_in_valid,
    input  logic                  data_in_last,
    input  logic                  w_wr_en,
    input  logic [ADDR_WIDTH-1:0] w_wr_addr,
    input  logic [BITWIDTH-1:0]   w_wr_data,
    input  logic                  b_wr_en,
    input  logic [CNT_WIDTH-1:0]  b_wr_addr,
    input  logic [BITWIDTH-1:0]   b_wr_data,
    output logic [BITWIDTH-1:0]   data_out,
    output logic                  data_out_valid,
    output logic [CNT_WIDTH-1:0]  out_index,
    output logic                  done,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  overrun_err
);

    localparam int PROD_W = 2 * BITWIDTH;
    localparam int N_W    = IN_LEN * OUT_LEN;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};

    logic signed [BITWIDTH-1:0]  w_mem    [N_W];
    logic signed [BITWIDTH-1:0]  bias_mem [OUT_LEN];
    logic signed [ACC_WIDTH-1:0] acc      [OUT_LEN];
    logic signed [ACC_WIDTH-1:0] snap     [OUT_LEN];

    logic signed [BITWIDTH-1:0]  cur_w    [OUT_LEN];
    logic signed [PROD_W-1:0]    prod     [OUT_LEN];
    logic signed [ACC_WIDTH-1:0] prod_ext [OUT_LEN];

    logic [CNT_WIDTH-1:0]        in_cnt;
    logic [CNT_WIDTH-1:0]        drain_idx;
    logic                        drain_active;

    logic signed [ACC_WIDTH-1:0] sel_snap;
    logic signed [BITWIDTH-1:0]  sel_bias;
    logic signed [ACC_WIDTH-1:0] bias_ext;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic signed [BITWIDTH-1:0]  result;

    logic at_last_pos;
    logic frame_end;
    logic bad_last;
    logic drain_final;
    logic cfg_ok;

    assign busy        = (in_cnt != '0) || drain_active;
    assign at_last_pos = (in_cnt == CNT_WIDTH'(IN_LEN - 1));
    assign bad_last    = data_in_valid && data_in_last && !at_last_pos;
    assign frame_end   = data_in_valid && at_last_pos;
    assign drain_final = (drain_idx == CNT_WIDTH'(OUT_LEN - 1));
    assign cfg_ok      = !busy;

    // Weight column for the current input position, then full-width products.
    always_comb begin
        for (int j = 0; j < OUT_LEN; j++) begin
            cur_w[j] = '0;
            for (int i = 0; i < IN_LEN; i++) begin
                if (in_cnt == CNT_WIDTH'(i)) begin
                    cur_w[j] = w_mem[j*IN_LEN + i];
                end
            end
            prod[j]     = PROD_W'(signed'(data_in)) * PROD_W'(cur_w[j]);
            prod_ext[j] = {{(ACC_WIDTH-PROD_W){prod[j][PROD_W-1]}}, prod[j]};
        end
    end

    // Drain datapath: bias is aligned to the product scale before the shift.
    always_comb begin
        sel_snap = '0;
        sel_bias = '0;
        for (int k = 0; k < OUT_LEN; k++) begin
            if (drain_idx == CNT_WIDTH'(k)) begin
                sel_snap = snap[k];
                sel_bias = bias_mem[k];
            end
        end
        bias_ext = {{(ACC_WIDTH-BITWIDTH){sel_bias[BITWIDTH-1]}}, sel_bias};
        sum      = sel_snap + (bias_ext <<< FRAC_BITS);
        shifted  = sum >>> FRAC_BITS;
        if ((RELU != 0) && (shifted < 0)) begin
            shifted = '0;
        end
        if (shifted > SAT_MAX) begin
            result = SAT_MAX[BITWIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            result = SAT_MIN[BITWIDTH-1:0];
        end else begin
            result = shifted[BITWIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < N_W; a++) w_mem[a] <= '0;
            for (int j = 0; j < OUT_LEN; j++) begin
                bias_mem[j] <= '0;
                acc[j]      <= '0;
                snap[j]     <= '0;
            end
            in_cnt         <= '0;
            drain_idx      <= '0;
            drain_active   <= 1'b0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            out_index      <= '0;
            done           <= 1'b0;
            frame_err      <= 1'b0;
            overrun_err    <= 1'b0;
        end else if (clken) begin
            data_out_valid <= 1'b0;
            done           <= 1'b0;

            if (drain_active) begin
                data_out       <= result;
                out_index      <= drain_idx;
                data_out_valid <= 1'b1;
                done           <= drain_final;
                if (drain_final) begin
                    drain_active <= 1'b0;
                end else begin
                    drain_idx <= drain_idx + 1'b1;
                end
            end

            if (bad_last) begin
                frame_err <= 1'b1;
                in_cnt    <= '0;
                for (int j = 0; j < OUT_LEN; j++) acc[j] <= '0;
            end else if (frame_end) begin
                for (int j = 0; j < OUT_LEN; j++) begin
                    snap[j] <= acc[j] + prod_ext[j];
                    acc[j]  <= '0;
                end
                in_cnt       <= '0;
                drain_active <= 1'b1;
                drain_idx    <= '0;
                // A drain emitting its final result this edge has completed.
                if (drain_active && !drain_final) begin
                    overrun_err <= 1'b1;
                end
            end else if (data_in_valid) begin
                for (int j = 0; j < OUT_LEN; j++) acc[j] <= acc[j] + prod_ext[j];
                in_cnt <= in_cnt + 1'b1;
            end

            if (cfg_ok && w_wr_en) begin
                for (int a = 0; a < N_W; a++) begin
                    if (w_wr_addr == ADDR_WIDTH'(a)) w_mem[a] <= w_wr_data;
                end
            end
            if (cfg_ok && b_wr_en) begin
                for (int j = 0; j < OUT_LEN; j++) begin
                    if (b_wr_addr == CNT_WIDTH'(j)) bias_mem[j] <= b_wr_data;
                end
            end
        end
    end

endmodule

`default_nettype wire
